// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with a per-register pending-write scoreboard, RAW stall and
// one valid/ready output slot. Define OPFETCH_WB_BYPASS_EN to forward the same-cycle writeback.
module operand_fetch #(
    parameter int XLEN      = 64,
    parameter int PAYLOAD_W = 32,
    parameter int PEND_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_we,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [4:0]           ra1,
    output logic [4:0]           ra2,
    input  logic [XLEN-1:0]      rd1,
    input  logic [XLEN-1:0]      rd2,
    input  logic                 wb_we,
    input  logic [4:0]           wb_wa,
    input  logic [XLEN-1:0]      wb_wd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [4:0]           out_rd,
    output logic                 out_rd_we,
    output logic [PAYLOAD_W-1:0] out_payload
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
`ifdef OPFETCH_WB_BYPASS_EN
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
`endif

    logic [PEND_W-1:0]    pend_q [32];
    logic [PEND_W-1:0]    pend_d [32];
    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      out_op1_q, out_op1_d;
    logic [XLEN-1:0]      out_op2_q, out_op2_d;
    logic [4:0]           out_rd_q, out_rd_d;
    logic                 out_rd_we_q, out_rd_we_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;

    logic            slot_free, haz1, haz2, cnt_full, ready_c, accept;
    logic [XLEN-1:0] op1_sel, op2_sel;
    logic [31:0]     inc_vec, dec_vec;

    assign ra1 = in_rs1;
    assign ra2 = in_rs2;

`ifndef OPFETCH_WB_BYPASS_EN
    logic unused_wb_wd;
    assign unused_wb_wd = ^wb_wd;
`endif

    // Issue decision: slot availability, RAW hazards and counter saturation
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        haz1      = (in_rs1 != 5'd0) && (pend_q[in_rs1] != '0);
        haz2      = (in_rs2 != 5'd0) && (pend_q[in_rs2] != '0);
        op1_sel   = (in_rs1 == 5'd0) ? '0 : rd1;
        op2_sel   = (in_rs2 == 5'd0) ? '0 : rd2;
`ifdef OPFETCH_WB_BYPASS_EN
        // The last outstanding write landing this cycle is forwarded, so it is not a hazard.
        if (pend_q[in_rs1] == PEND_ONE && wb_we && wb_wa == in_rs1) haz1 = 1'b0;
        if (pend_q[in_rs2] == PEND_ONE && wb_we && wb_wa == in_rs2) haz2 = 1'b0;
        if (in_rs1 != 5'd0 && wb_we && wb_wa == in_rs1) op1_sel = wb_wd;
        if (in_rs2 != 5'd0 && wb_we && wb_wa == in_rs2) op2_sel = wb_wd;
`endif
        cnt_full = in_rd_we && (in_rd != 5'd0) && (pend_q[in_rd] == PEND_MAX)
                   && !(wb_we && wb_wa == in_rd);
        ready_c  = slot_free && !haz1 && !haz2 && !cnt_full && !flush;
        accept   = in_valid && ready_c;
    end

    assign in_ready = ready_c;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_rd_d      = out_rd_q;
        out_rd_we_d   = out_rd_we_q;
        out_payload_d = out_payload_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_op1_d     = op1_sel;
            out_op2_d     = op2_sel;
            out_rd_d      = in_rd;
            out_rd_we_d   = in_rd_we && (in_rd != 5'd0);
            out_payload_d = in_payload;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard: simultaneous issue and writeback to one register cancel out
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < 32; i++) begin
            pend_d[i] = pend_q[i];
            if (i != 0) begin
                inc_vec[i] = accept && in_rd_we && (in_rd == 5'(i));
                dec_vec[i] = wb_we && (wb_wa == 5'(i)) && (pend_q[i] != '0);
            end
            if (flush) begin
                pend_d[i] = '0;
            end else if (inc_vec[i] && !dec_vec[i]) begin
                pend_d[i] = pend_q[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            out_payload_q <= '0;
            for (int i = 0; i < 32; i++) pend_q[i] <= '0;
        end else begin
            assert (flush || !wb_we || wb_wa == 5'd0 || pend_q[wb_wa] != '0)
                else $error("operand_fetch: writeback to x%0d with no pending write", wb_wa);
            out_valid_q   <= out_valid_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_rd_q      <= out_rd_d;
            out_rd_we_q   <= out_rd_we_d;
            out_payload_q <= out_payload_d;
            for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_payload = out_payload_q;
endmodule
